// File: rtl/redop_pkg.sv
// Shared opcode encodings, FSM states and opcode helper functions for the
// sequential reduction unit.
package redop_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;

   localparam logic [1:0] BASE_AND = 2'd0;
   localparam logic [1:0] BASE_OR  = 2'd1;
   localparam logic [1:0] BASE_XOR = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [1:0] op_base(input logic [2:0] op);
      case (op)
         OP_AND, OP_NAND: return BASE_AND;
         OP_OR, OP_NOR:   return BASE_OR;
         default:         return BASE_XOR;
      endcase
   endfunction

   // AND-family folds start from 1, OR/XOR-family folds start from 0.
   function automatic logic op_identity(input logic [2:0] op);
      return (op_base(op) == BASE_AND);
   endfunction

   function automatic logic op_invert(input logic [2:0] op);
      case (op)
         OP_NAND, OP_NOR, OP_XNOR: return 1'b1;
         default:                  return 1'b0;
      endcase
   endfunction

   function automatic logic op_illegal(input logic [2:0] op);
      return (op > OP_XNOR);
   endfunction

   function automatic logic op_fold(input logic [1:0] base, input logic acc, input logic part);
      case (base)
         BASE_AND: return acc & part;
         BASE_OR:  return acc | part;
         default:  return acc ^ part;
      endcase
   endfunction

endpackage

// File: rtl/redop_chunk.sv
// Combinational reduction of one CHUNK-bit slice under a base operator.
module redop_chunk
   import redop_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] slice,
   input  logic [1:0]       base,
   output logic             part
);

   // Reduce the slice with the selected base operator.
   always_comb begin
      part = 1'b0;
      case (base)
         BASE_AND: part = &slice;
         BASE_OR:  part = |slice;
         BASE_XOR: part = ^slice;
         default:  part = 1'b0;
      endcase
   end

endmodule

// File: rtl/redop_seq_unit.sv
// Sequential multi-cycle reduction unit: accepts a WIDTH-bit operand, folds
// CHUNK bits per cycle and returns a tagged 1-bit result.
module redop_seq_unit
   import redop_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8,
   parameter int NCH   = 4,
   localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [CW-1:0]    in_chan,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic [CW-1:0]    out_chan,
   output logic             out_err,
   output logic [NCH-1:0]   res_vec
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NCHUNK - 1);

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("redop_seq_unit: WIDTH must be a multiple of CHUNK");
   end

   state_t           state_r;
   state_t           state_nx_s;
   logic             ready_r;
   logic [WIDTH-1:0] shift_r;
   logic [2:0]       op_r;
   logic [CW-1:0]    chan_r;
   logic             chan_bad_r;
   logic             acc_r;
   logic [CNTW-1:0]  cnt_r;
   logic             out_valid_r;
   logic             out_bit_r;
   logic [CW-1:0]    out_chan_r;
   logic             out_err_r;
   logic [NCH-1:0]   res_vec_r;
   logic             part_s;
   logic             accept_s;
   logic             err_s;

   assign accept_s = in_valid && ready_r;
   assign err_s    = op_illegal(op_r) || chan_bad_r;

   redop_chunk #(.CHUNK(CHUNK)) u_chunk (
      .slice (shift_r[CHUNK-1:0]),
      .base  (op_base(op_r)),
      .part  (part_s)
   );

   // Next-state decode for the IDLE -> RUN -> DONE sequence.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_nx_s = ST_RUN;
            else          state_nx_s = ST_IDLE;
         end
         ST_RUN: begin
            if (cnt_r == CNT_LAST) state_nx_s = ST_DONE;
            else                   state_nx_s = ST_RUN;
         end
         ST_DONE: begin
            if (out_valid_r && out_ready) state_nx_s = ST_IDLE;
            else                          state_nx_s = ST_DONE;
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State register, datapath and registered result/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         ready_r     <= 1'b0;
         shift_r     <= '0;
         op_r        <= 3'd0;
         chan_r      <= '0;
         chan_bad_r  <= 1'b0;
         acc_r       <= 1'b0;
         cnt_r       <= '0;
         out_valid_r <= 1'b0;
         out_bit_r   <= 1'b0;
         out_chan_r  <= '0;
         out_err_r   <= 1'b0;
         res_vec_r   <= '0;
      end else begin
         state_r <= state_nx_s;
         // Ready tracks the IDLE state but stays low for the first cycle out of reset.
         ready_r <= (state_nx_s == ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  shift_r    <= in_data;
                  op_r       <= in_op;
                  chan_r     <= in_chan;
                  chan_bad_r <= (32'(in_chan) >= 32'(NCH));
                  acc_r      <= op_identity(in_op);
                  cnt_r      <= '0;
               end
            end
            ST_RUN: begin
               acc_r   <= op_fold(op_base(op_r), acc_r, part_s);
               shift_r <= shift_r >> CHUNK;
               cnt_r   <= cnt_r + CNTW'(1);
            end
            ST_DONE: begin
               // Results are published one cycle after the final fold and then held.
               if (!out_valid_r) begin
                  out_valid_r <= 1'b1;
                  out_err_r   <= err_s;
                  out_chan_r  <= chan_r;
                  out_bit_r   <= err_s ? 1'b0 : (acc_r ^ op_invert(op_r));
                  if (!err_s) begin
                     res_vec_r[chan_r] <= acc_r ^ op_invert(op_r);
                  end
               end else if (out_ready) begin
                  out_valid_r <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = ready_r;
   assign out_valid = out_valid_r;
   assign out_bit   = out_bit_r;
   assign out_chan  = out_chan_r;
   assign out_err   = out_err_r;
   assign res_vec   = res_vec_r;

endmodule

// File: tb/tb_redop_seq_unit.sv
// Randomised and directed bench for redop_seq_unit against a behavioural
// reduction model; a second instance covers the single-cycle CHUNK == WIDTH build.
module tb_redop_seq_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [2:0]  in_op = 3'd0;
   logic [1:0]  in_chan = 2'd0;
   logic [31:0] in_data = 32'd0;
   logic        out_valid, out_ready = 1'b0, out_bit, out_err;
   logic [1:0]  out_chan;
   logic [3:0]  res_vec;

   logic        s_in_valid = 1'b0, s_in_ready;
   logic [2:0]  s_in_op = 3'd0;
   logic [1:0]  s_in_chan = 2'd0;
   logic [31:0] s_in_data = 32'd0;
   logic        s_out_valid, s_out_ready = 1'b0, s_out_bit, s_out_err;
   logic [1:0]  s_out_chan;
   logic [3:0]  s_res_vec;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_vec = 4'd0;

   always #5 clk = ~clk;

   redop_seq_unit #(.WIDTH(32), .CHUNK(8), .NCH(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_chan(in_chan), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_bit(out_bit), .out_chan(out_chan), .out_err(out_err), .res_vec(res_vec)
   );

   redop_seq_unit #(.WIDTH(32), .CHUNK(32), .NCH(4)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op),
      .in_chan(s_in_chan), .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_bit(s_out_bit), .out_chan(s_out_chan), .out_err(s_out_err), .res_vec(s_res_vec)
   );

   function automatic void model(input logic [2:0] op, input logic [31:0] d,
                                 output logic b, output logic e);
      logic r;
      e = (op > 3'd5);
      case (op)
         3'd0, 3'd2: r = (d == 32'hFFFF_FFFF);
         3'd1, 3'd3: r = (d != 32'd0);
         default:    r = (($countones(d) % 2) == 1);
      endcase
      if (op == 3'd2 || op == 3'd3 || op == 3'd5) r = !r;
      b = e ? 1'b0 : r;
   endfunction

   // Present one operand (called #1 after a rising edge) and return when out_valid appears.
   task automatic send(input logic [2:0] op, input logic [1:0] ch, input logic [31:0] d,
                       output int lat);
      int guard = 0;
      in_valid = 1'b1; in_op = op; in_chan = ch; in_data = d;
      while (!in_ready && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic complete();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, out_bit, out_chan, out_err, res_vec} !== 10'd0) begin
         errors++;
         $display("FAIL reset_outputs got %b required 0", {in_ready, out_valid, out_bit, out_chan, out_err, res_vec});
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b required 1", in_ready);
      end
      exp_vec = 4'd0;
   endtask

   task automatic test_directed();
      logic [2:0]  ops [5] = '{3'd0, 3'd0, 3'd5, 3'd4, 3'd3};
      logic [31:0] dat [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000};
      logic        bits[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [3:0]  vecs[5] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010};
      int lat;
      for (int i = 0; i < 5; i++) begin
         send(ops[i], 2'd1, dat[i], lat);
         checks++;
         if (lat !== 5) begin
            errors++; $display("FAIL dir_latency[%0d] got %0d required 5", i, lat);
         end
         checks++;
         if (out_bit !== bits[i] || out_err !== 1'b0 || out_chan !== 2'd1) begin
            errors++;
            $display("FAIL dir_result[%0d] got bit=%b err=%b chan=%0d required bit=%b err=0 chan=1", i, out_bit, out_err, out_chan, bits[i]);
         end
         checks++;
         if (res_vec !== vecs[i]) begin
            errors++; $display("FAIL dir_res_vec[%0d] got %b required %b", i, res_vec, vecs[i]);
         end
         complete();
      end
      exp_vec = 4'b0010;
   endtask

   task automatic test_backpressure();
      int lat;
      logic b0;
      send(3'd1, 2'd3, 32'h0001_0000, lat);
      b0 = out_bit;
      checks++;
      if (b0 !== 1'b1) begin
         errors++; $display("FAIL bp_bit got %b required 1", b0);
      end
      in_valid = 1'b1; in_op = 3'd0; in_data = 32'd0; in_chan = 2'd0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || out_bit !== 1'b1 || out_chan !== 2'd3 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d] got valid=%b bit=%b chan=%0d in_ready=%b required 1 1 3 0", i, out_valid, out_bit, out_chan, in_ready);
         end
      end
      in_valid = 1'b0;
      complete();
      exp_vec[3] = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || res_vec !== exp_vec) begin
         errors++;
         $display("FAIL bp_release got valid=%b in_ready=%b vec=%b required 0 1 %b", out_valid, in_ready, res_vec, exp_vec);
      end
   endtask

   task automatic test_illegal();
      int lat;
      send(3'd7, 2'd2, $urandom, lat);
      checks++;
      if (out_err !== 1'b1 || out_bit !== 1'b0 || out_chan !== 2'd2 || res_vec !== exp_vec) begin
         errors++;
         $display("FAIL illegal got err=%b bit=%b chan=%0d vec=%b required 1 0 2 %b", out_err, out_bit, out_chan, res_vec, exp_vec);
      end
      complete();
   endtask

   task automatic test_random();
      int lat;
      logic [2:0] op;
      logic [1:0] ch;
      logic [31:0] d;
      logic eb, ee;
      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(0, 7));
         ch = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       d = 32'hFFFF_FFFF;
            1:       d = 32'd0;
            default: d = $urandom;
         endcase
         model(op, d, eb, ee);
         if (!ee) exp_vec[ch] = eb;
         out_ready = ($urandom_range(0, 1) == 1);
         send(op, ch, d, lat);
         checks++;
         if (lat !== 5 || out_bit !== eb || out_err !== ee || out_chan !== ch || res_vec !== exp_vec) begin
            errors++;
            $display("FAIL rand[%0d] op=%0d d=%h got lat=%0d bit=%b err=%b chan=%0d vec=%b required 5 %b %b %0d %b",
                     i, op, d, lat, out_bit, out_err, out_chan, res_vec, eb, ee, ch, exp_vec);
         end
         complete();
      end
   endtask

   task automatic test_single_cycle();
      int lat;
      logic [31:0] d;
      logic eb, ee;
      d = $urandom;
      model(3'd4, d, eb, ee);
      s_in_valid = 1'b1; s_in_op = 3'd4; s_in_chan = 2'd0; s_in_data = d;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      lat = 0;
      while (!s_out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      checks++;
      if (lat !== 2 || s_out_bit !== eb || s_out_err !== 1'b0 || s_res_vec !== {3'b000, eb}) begin
         errors++;
         $display("FAIL single_cycle got lat=%0d bit=%b err=%b vec=%b required 2 %b 0 %b", lat, s_out_bit, s_out_err, s_res_vec, eb, {3'b000, eb});
      end
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_out_ready = 1'b0;
   endtask

   task automatic test_midrun_reset();
      int seen = 0;
      in_valid = 1'b1; in_op = 3'd0; in_chan = 2'd0; in_data = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_vec = 4'd0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0 || res_vec !== 4'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrun_reset got valid_cycles=%0d vec=%b in_ready=%b required 0 0000 1", seen, res_vec, in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_illegal();
      test_random();
      test_single_cycle();
      test_midrun_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
